// File: rtl/gpu_sched_pkg.sv
// Shared scheduling types for the GPU core-array control blocks.
package gpu_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_RELEASE,
        ST_DONE
    } barrier_state_e;

endpackage

// File: rtl/barrier_watchdog.sv
// Per-phase watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the count reaches limit-1. A zero limit never expires.
module barrier_watchdog #(
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [TIMEOUT_W-1:0] limit,
    output logic                 expired
);

    logic [TIMEOUT_W-1:0] count;

    // Saturating counter so a very long wait with the watchdog off cannot wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + TIMEOUT_W'(1);
        end
    end

    assign expired = enable && (limit != '0) && (count == (limit - TIMEOUT_W'(1)));

endmodule

// File: rtl/barrier_sequencer.sv
// Multi-phase kernel/barrier controller: launches cores, collects per-core
// completion, releases the barrier each phase and reports done/timeout.
module barrier_sequencer
    import gpu_sched_pkg::*;
#(
    parameter int NUM_CORES = 1,
    parameter int PHASE_W   = 8,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 launch_valid,
    output logic                 launch_ready,
    input  logic [PHASE_W-1:0]   launch_phases,
    input  logic [NUM_CORES-1:0] launch_mask,
    input  logic [TIMEOUT_W-1:0] timeout_limit,
    input  logic                 abort,
    output logic [NUM_CORES-1:0] core_start,
    input  logic [NUM_CORES-1:0] core_done,
    output logic                 barrier_release,
    output logic [PHASE_W-1:0]   phase_idx,
    output logic [NUM_CORES-1:0] arrived_mask,
    output logic                 busy,
    output logic                 done_pulse,
    output logic                 timeout_err
);

    barrier_state_e state;

    logic [PHASE_W-1:0]   phases_q;
    logic [NUM_CORES-1:0] mask_q;
    logic [TIMEOUT_W-1:0] limit_q;
    logic [NUM_CORES-1:0] arrived_next;
    logic                 all_arrived;
    logic                 last_phase;
    logic                 wd_expired;

    assign arrived_next = arrived_mask | (core_done & mask_q);
    assign all_arrived  = (arrived_next == mask_q);
    assign last_phase   = (phase_idx == (phases_q - PHASE_W'(1)));

    barrier_watchdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == ST_START),
        .enable  (state == ST_WAIT),
        .limit   (limit_q),
        .expired (wd_expired)
    );

    // Every output is a register loaded alongside the transition into the state
    // that owns it, so pulses line up exactly with the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            launch_ready    <= 1'b1;
            busy            <= 1'b0;
            core_start      <= '0;
            barrier_release <= 1'b0;
            done_pulse      <= 1'b0;
            timeout_err     <= 1'b0;
            phase_idx       <= '0;
            arrived_mask    <= '0;
            phases_q        <= '0;
            mask_q          <= '0;
            limit_q         <= '0;
        end else begin
            core_start      <= '0;
            barrier_release <= 1'b0;
            done_pulse      <= 1'b0;
            if (abort && (state != ST_IDLE)) begin
                state        <= ST_IDLE;
                launch_ready <= 1'b1;
                busy         <= 1'b0;
                phase_idx    <= '0;
                arrived_mask <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (launch_valid && launch_ready) begin
                            phases_q     <= launch_phases;
                            mask_q       <= launch_mask;
                            limit_q      <= timeout_limit;
                            phase_idx    <= '0;
                            arrived_mask <= '0;
                            timeout_err  <= 1'b0;
                            launch_ready <= 1'b0;
                            busy         <= 1'b1;
                            if ((launch_phases == '0) || (launch_mask == '0)) begin
                                state      <= ST_DONE;
                                done_pulse <= 1'b1;
                            end else begin
                                state      <= ST_START;
                                core_start <= launch_mask;
                            end
                        end
                    end
                    ST_START: begin
                        arrived_mask <= '0;
                        state        <= ST_WAIT;
                    end
                    // Arrival is checked before the watchdog so a last-cycle arrival wins.
                    ST_WAIT: begin
                        arrived_mask <= arrived_next;
                        if (all_arrived) begin
                            state           <= ST_RELEASE;
                            barrier_release <= 1'b1;
                        end else if (wd_expired) begin
                            timeout_err <= 1'b1;
                            state       <= ST_DONE;
                            done_pulse  <= 1'b1;
                        end
                    end
                    ST_RELEASE: begin
                        if (last_phase) begin
                            state      <= ST_DONE;
                            done_pulse <= 1'b1;
                        end else begin
                            phase_idx  <= phase_idx + PHASE_W'(1);
                            state      <= ST_START;
                            core_start <= mask_q;
                        end
                    end
                    ST_DONE: begin
                        state        <= ST_IDLE;
                        launch_ready <= 1'b1;
                        busy         <= 1'b0;
                    end
                    default: begin
                        state        <= ST_IDLE;
                        launch_ready <= 1'b1;
                        busy         <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
